// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the arithmetic lab datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;
    localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

    // Step counter must hold the values 0..width.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract for the restoring divider: t = r_shift - {0,d} as a two's-complement add.
// Purely combinational, zero latency; no flow control.
// Always ready; the result is valid whenever its inputs are.
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   r_shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   t,
    output logic             ge
);

    // Invert B and inject carry-in 1, matching the add/sub unit in subtract mode.
    assign t  = r_shift + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
    assign ge = ~t[WIDTH];

endmodule

// File: rtl/seq_div4.sv
// Iterative unsigned restoring divider, one shift/trial-subtract step per clock.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero finishes in 1 cycle.
// start is ignored while busy; a start during the done cycle is accepted back-to-back.
module seq_div4
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    // Partial remainder never exceeds the divisor, so WIDTH bits hold it;
    // the extra bit only exists in the shifted trial value.
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             last_step;
    logic             accept;

    assign r_shift   = {r_q, q_q[WIDTH-1]};
    assign r_step    = ge ? t[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_step    = {q_q[WIDTH-2:0], ge};
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept    = start && (state_q != CALC);

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .r_shift (r_shift),
        .d       (d_q),
        .t       (t),
        .ge      (ge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (accept) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d_q         <= divisor;
            q_q         <= dividend;
            r_q         <= '0;
            cnt_q       <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state_q == CALC) begin
            r_q   <= r_step;
            q_q   <= q_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
                quotient  <= q_step;
                remainder <= r_step;
            end
        end
    end

endmodule

// File: tb/tb_seq_div4.sv
module tb_seq_div4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor = 4'd0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int lat;
    int bcnt;
    int dcnt;
    logic [3:0] cap_q;
    logic [3:0] cap_r;

    seq_div4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with operands; return in the done cycle with lat = cycles since the start edge.
    task automatic op(input logic [3:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
            step();
        end
        if (lat == 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        step();

        // 13 / 3
        op(4'd13, 4'd3);
        chk("13_3_lat", 32'(lat), 32'd5);
        chk("13_3_busy_cycles", 32'(bcnt), 32'd4);
        chk("13_3_q", 32'(quotient), 32'd4);
        chk("13_3_r", 32'(remainder), 32'd1);
        chk("13_3_dbz", 32'(div_by_zero), 32'd0);
        step();
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("hold_q", 32'(quotient), 32'd4);

        // Boundaries
        op(4'd15, 4'd1);
        chk("15_1_q", 32'(quotient), 32'd15);
        chk("15_1_r", 32'(remainder), 32'd0);
        op(4'd2, 4'd7);
        chk("2_7_q", 32'(quotient), 32'd0);
        chk("2_7_r", 32'(remainder), 32'd2);
        op(4'd0, 4'd5);
        chk("0_5_q", 32'(quotient), 32'd0);
        chk("0_5_r", 32'(remainder), 32'd0);
        op(4'd15, 4'd15);
        chk("15_15_q", 32'(quotient), 32'd1);
        chk("15_15_r", 32'(remainder), 32'd0);

        // Divide by zero, then a normal op clears the flag
        op(4'd9, 4'd0);
        chk("9_0_lat", 32'(lat), 32'd1);
        chk("9_0_q", 32'(quotient), 32'd15);
        chk("9_0_r", 32'(remainder), 32'd9);
        chk("9_0_dbz", 32'(div_by_zero), 32'd1);
        step();
        chk("9_0_dbz_hold", 32'(div_by_zero), 32'd1);
        op(4'd6, 4'd2);
        chk("6_2_q", 32'(quotient), 32'd3);
        chk("6_2_r", 32'(remainder), 32'd0);
        chk("6_2_dbz", 32'(div_by_zero), 32'd0);
        step();

        // Start while busy is ignored
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        step();
        start = 1'b0;
        step();
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd7;
        step();
        step();
        start = 1'b0;
        dcnt  = 0;
        cap_q = 4'd0;
        cap_r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dcnt++;
                cap_q = quotient;
                cap_r = remainder;
            end
            step();
        end
        chk("busy_rej_dones", 32'(dcnt), 32'd1);
        chk("busy_rej_q", 32'(cap_q), 32'd3);
        chk("busy_rej_r", 32'(cap_r), 32'd2);

        // Back-to-back: start held through the done cycle
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd2;
        step();
        dividend = 4'd12;
        divisor  = 4'd5;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            step();
        end
        chk("b2b_first_lat", 32'(lat), 32'd5);
        chk("b2b_first_q", 32'(quotient), 32'd5);
        chk("b2b_first_r", 32'(remainder), 32'd1);
        step();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            step();
        end
        chk("b2b_second_gap", 32'(lat), 32'd5);
        chk("b2b_second_q", 32'(quotient), 32'd2);
        chk("b2b_second_r", 32'(remainder), 32'd2);

        // Asynchronous reset mid-operation
        step();
        start    = 1'b1;
        dividend = 4'd10;
        divisor  = 4'd3;
        step();
        start = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) dcnt++;
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);
        op(4'd10, 4'd3);
        chk("after_rst_q", 32'(quotient), 32'd3);
        chk("after_rst_r", 32'(remainder), 32'd1);

        // Exhaustive sweep against the arithmetic identity
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic ok;
                int qv;
                int rv;
                op(4'(a), 4'(b));
                qv = int'(quotient);
                rv = int'(remainder);
                if (b == 0) ok = (qv == 15) && (rv == a) && div_by_zero && (lat == 1);
                else ok = (qv * b + rv == a) && (rv < b) && (qv == a / b) &&
                          !div_by_zero && (lat == 5);
                if (!ok) $display("sweep detail a=%0d b=%0d q=%0d r=%0d lat=%0d", a, b, qv, rv, lat);
                chk("sweep", 32'(ok), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
